mul16_seq: RTL and testbench
============================

# mul16_seq

Sequential 16×16 multiplier controller that time-multiplexes one existing `Add16` ripple adder over up to 16 shift-and-add iterations. It produces the low 16 bits of the product, which is identical for signed and unsigned two's-complement operands. Operands arrive on a valid/ready input handshake and the result leaves on a valid/ready output handshake. It sits beside the ALU as the multi-cycle multiply unit.

## Interface
- `WIDTH`, 16: operand/result width; fixed at 16 because the adder is 16-bit.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous abort, returns to IDLE.
- `in_valid` in 1: operands present.
- `in_ready` out 1: high only in IDLE.
- `a` in 16: multiplicand.
- `b` in 16: multiplier.
- `out_valid` out 1: result present (DONE state).
- `out_ready` in 1: consumer accepts result.
- `out` out 16: `(a*b) mod 2^16`; held stable while `out_valid`.
- `busy` out 1: high in RUN.

## Operation
- States:
  - **IDLE**:
    - `in_ready`=1.
    - On `in_valid & in_ready`: latch `mcand`=a, `mplier`=b, `acc`=0; go to RUN.
  - **RUN**, one iteration per cycle:
    - If `mplier[0]`: `acc` <= Add16(`acc`, `mcand`); otherwise `acc` holds.
    - `mcand` <= `mcand`<<1 (bits shifted past bit 15 are discarded).
    - `mplier` <= `mplier`>>1 (zero-fill).
    - `cnt` <= `cnt`+1, where `cnt` is 4 bits and is cleared on accept.
    - Leave RUN for DONE when `(mplier>>1)==0` (early termination) or `cnt==15`.
  - **DONE**:
    - `out_valid`=1, `out`=`acc`.
    - On `out_ready`: go to IDLE.
    - `out_valid` and `out` stay stable until the handshake completes.
- The adder carry-out is not used; all arithmetic wraps mod 2^16.
- `b`=0 still spends exactly one RUN cycle, and the result is 0.
- No overlap: `in_ready` is low in RUN and DONE, so a new accept cannot happen in the same cycle as the output handshake.
- `flush` outranks every other event in every state:
  - Next state is IDLE; `acc`, `cnt` are cleared.
  - Any pending result is dropped without `out_valid` completing.
- Reset values: state IDLE; `in_ready`=1; `out_valid`=0, `busy`=0, `out`=0x0000; internal registers 0.
- Asserting `rst_n` low during RUN or DONE aborts immediately and asynchronously to the values above.

## Timing
- Accept edge E0. RUN occupies edges E1..EN, where N = max(1, index of the highest set bit of `b` + 1), so 1 ≤ N ≤ 16.
- `out_valid` rises after edge EN, i.e. N cycles after accept.
- Output handshake at edge EH returns to IDLE; `in_ready` is high in the cycle after EH.
- Minimum initiation interval is N+2 cycles.
- `busy`, `in_ready` and `out_valid` are decoded from registered state, so none of them has a combinational path from the inputs.
- The critical path is one Add16 carry chain plus the `acc` mux per cycle.

## Structure
- The shared header holds:
  - the state encodings (`IDLE`=2'd0, `RUN`=2'd1, `DONE`=2'd2);
  - the `WIDTH` constant;
  - the counter limit 15.
- The state encoding 2'd3 is unreachable; it decodes to IDLE on the next edge.
- One sub-module is instantiated: the existing `Add16`, with operands `acc` and `mcand`. No other arithmetic is inferred for the accumulation.
- FSM, shift registers and counter live in `mul16_seq` itself.

## Test plan
- a=3, b=5 → `out`=0x000F; `out_valid` rises 3 cycles after accept; `busy` is high for exactly 3 cycles.
- a=0x1234, b=0 → `out`=0x0000 after 1 RUN cycle. Then a=0xFFFF, b=0xFFFF → `out`=0x0001 after 16 RUN cycles.
- a=300, b=300 → `out`=0x5F90 (90000 mod 65536). Also a=0xFFFE(−2), b=0x0003 → `out`=0xFFFA(−6).
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE.
  - `out` stays stable and `in_ready` stays 0 throughout.
  - `in_valid` pulsed during this window is ignored.
  - After the handshake, the next op is accepted one cycle later.
- Pulse `flush` in RUN of a=7, b=0x8000 → IDLE next cycle with no `out_valid`; a subsequent a=2, b=2 → 0x0004.
- Drive `rst_n` low mid-RUN → `busy`, `out_valid` and `out` go to 0 without waiting for a clock edge; `in_ready`=1; normal operation resumes after release.

Source files
------------

// File: rtl/mul16_seq_pkg.sv
// Shared definitions for the sequential 16x16 multiplier: operand width,
// controller state encoding and the iteration counter limit.
package mul16_seq_pkg;

  localparam int WIDTH = 16;

  localparam logic [3:0] CNT_LIMIT = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul16_seq_add16.sv
// Add16: plain 16-bit ripple-carry adder shared by the multiplier datapath.
module Add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic        cout
);

  // Ripple the carry bit by bit from the LSB upward.
  always_comb begin
    logic carry;
    carry = 1'b0;
    sum   = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/mul16_seq.sv
// mul16_seq: shift-and-add multiplier producing (a*b) mod 2^16 over up to
// 16 iterations of a single shared Add16, with valid/ready on both sides.
module mul16_seq
  import mul16_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [3:0]       cnt;

  logic [WIDTH-1:0] sum;
  logic             add_cout_unused;
  logic [WIDTH-1:0] acc_next;
  logic             run_last;

  // The carry-out is deliberately dropped: accumulation wraps mod 2^16.
  Add16 u_add16 (
    .a    (acc),
    .b    (mcand),
    .sum  (sum),
    .cout (add_cout_unused)
  );

  // Next accumulator value and the "this is the final RUN cycle" decision.
  always_comb begin
    acc_next = acc;
    run_last = 1'b0;
    if (mplier[0]) begin
      acc_next = sum;
    end else begin
      acc_next = acc;
    end
    if (((mplier >> 1) == 16'h0000) || (cnt == CNT_LIMIT)) begin
      run_last = 1'b1;
    end else begin
      run_last = 1'b0;
    end
  end

  // Controller FSM, operand shift registers, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mcand     <= 16'h0000;
      mplier    <= 16'h0000;
      acc       <= 16'h0000;
      cnt       <= 4'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out       <= 16'h0000;
    end else if (flush) begin
      state     <= IDLE;
      mcand     <= 16'h0000;
      mplier    <= 16'h0000;
      acc       <= 16'h0000;
      cnt       <= 4'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out       <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mcand    <= a;
            mplier   <= b;
            acc      <= 16'h0000;
            cnt      <= 4'd0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 4'd1;
          if (run_last) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            out       <= acc_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out       <= 16'h0000;
          end
        end
        default: begin
          // Unreachable encoding: fall back to IDLE on the next edge.
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          out       <= 16'h0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul16_seq.sv
// Self-checking bench for mul16_seq: directed vector table, hand-written
// handshake/flush/reset sequences and randomized ops against a product model.
module tb_mul16_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_o;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mul16_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_o),
    .busy      (busy)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_out;
    int          exp_lat;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [15:0] model_prod(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] p;
    p = {16'h0000, x} * {16'h0000, y};
    return p[15:0];
  endfunction

  // Cycles in RUN: position of the highest set bit of the multiplier, at least 1.
  function automatic int model_lat(input logic [15:0] y);
    int n;
    n = 1;
    for (int i = 0; i < 16; i++) begin
      if (y[i]) n = i + 1;
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present operands at a negedge; they are accepted at the next rising edge.
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv);
    @(negedge clk);
    a_i      = av;
    b_i      = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count cycles from accept until out_valid, and cycles with busy high.
  task automatic wait_out(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (!out_valid && lat < 40) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) check("timeout_out_valid", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] exp_o, input int exp_l, input string tag);
    int lat;
    int bc;
    out_ready = 1'b1;
    start_op(av, bv);
    wait_out(lat, bc);
    check({tag, "_out"}, 32'(out_o), 32'(exp_o));
    check({tag, "_lat"}, 32'(lat), 32'(exp_l));
    check({tag, "_busy_cycles"}, 32'(bc), 32'(exp_l));
    check({tag, "_busy_low_done"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int bc;
    int seen;
    logic [15:0] held;
    logic [15:0] ra;
    logic [15:0] rb;

    vecs[0] = '{a: 16'h0003, b: 16'h0005, exp_out: 16'h000F, exp_lat: 3};
    vecs[1] = '{a: 16'h1234, b: 16'h0000, exp_out: 16'h0000, exp_lat: 1};
    vecs[2] = '{a: 16'hFFFF, b: 16'hFFFF, exp_out: 16'h0001, exp_lat: 16};
    vecs[3] = '{a: 16'd300,  b: 16'd300,  exp_out: 16'h5F90, exp_lat: 9};
    vecs[4] = '{a: 16'hFFFE, b: 16'h0003, exp_out: 16'hFFFA, exp_lat: 2};

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_i       = 16'h0000;
    b_i       = 16'h0000;

    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out", 32'(out_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i].a, vecs[i].b, vecs[i].exp_out, vecs[i].exp_lat, $sformatf("vec%0d", i));
    end

    // Backpressure in DONE with an ignored in_valid pulse
    out_ready = 1'b0;
    start_op(16'h00AB, 16'h0011);
    wait_out(lat, bc);
    check("bp_lat", 32'(lat), 32'(model_lat(16'h0011)));
    held = out_o;
    check("bp_out", 32'(held), 32'(model_prod(16'h00AB, 16'h0011)));
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        a_i = 16'h5555;
        b_i = 16'h7777;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check("bp_out_stable", 32'(out_o), 32'(held));
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_out_valid_high", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_hs_in_ready", 32'(in_ready), 32'd1);
    check("bp_hs_out_valid", 32'(out_valid), 32'd0);
    start_op(16'h0009, 16'h0006);
    check("bp_next_accept_busy", 32'(busy), 32'd1);
    wait_out(lat, bc);
    check("bp_next_out", 32'(out_o), 32'(model_prod(16'h0009, 16'h0006)));
    @(posedge clk);
    #1;

    // Flush mid-RUN drops the result
    start_op(16'h0007, 16'h8000);
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("flush_no_result", 32'(seen), 32'd0);
    run_vec(16'h0002, 16'h0002, 16'h0004, 2, "post_flush");

    // Asynchronous reset mid-RUN
    start_op(16'hFFFF, 16'hFFFF);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_run_busy", 32'(busy), 32'd0);
    check("arst_run_out_valid", 32'(out_valid), 32'd0);
    check("arst_run_out", 32'(out_o), 32'd0);
    check("arst_run_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset while holding a result in DONE
    out_ready = 1'b0;
    start_op(16'h0003, 16'h0005);
    wait_out(lat, bc);
    check("arst_done_pre_out", 32'(out_o), 32'h000F);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_done_out", 32'(out_o), 32'd0);
    check("arst_done_out_valid", 32'(out_valid), 32'd0);
    check("arst_done_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(16'h0005, 16'h0007, 16'h0023, 3, "post_rst");

    // Randomized ops against the product model
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom) >> $urandom_range(0, 16);
      run_vec(ra, rb, model_prod(ra, rb), model_lat(rb), $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
